// File: rtl/tick_burst_pkg.sv
// Shared types for the tick-timed burst generator.
// The state encoding is visible to the FSM and to anything that decodes it.
package tick_burst_pkg;

   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/tick_down_counter.sv
// Phase-width counter: loads max(width,1), decrements on enabled ticks,
// and flags when the current phase is on its final tick.
module tick_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_tick,
   output logic             o_is_one
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_load_val;

   // A zero width would never reach the ==1 terminal value, so it runs as one tick.
   assign w_load_val = (i_load_val == '0) ? CNT_W'(1) : i_load_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= w_load_val;
      end else if (i_en && i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tick_burst_gen.sv
// Burst waveform generator: emits burst_len pulses whose high and low widths
// are measured in upstream ticks, with abort and a one-cycle done strobe.
module tick_burst_gen
   import tick_burst_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] burst_len,
   input  logic [CNT_W-1:0] high_ticks,
   input  logic [CNT_W-1:0] low_ticks,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_low;
   logic [CNT_W-1:0] r_pulse_cnt;

   logic             w_accept;
   logic             w_pulse_inc;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_cnt_en;
   logic             w_cnt_is_one;
   logic [CNT_W:0]   w_cnt_plus1;
   logic             w_last;

   // One extra bit so a full-scale burst_len compares without wrapping.
   assign w_cnt_plus1 = {1'b0, r_pulse_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_last      = (w_cnt_plus1 == {1'b0, r_len});

   assign w_cnt_en = ((r_state == HIGH) || (r_state == LOW)) && !abort;

   tick_down_counter #(
      .CNT_W (CNT_W)
   ) u_width_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_cnt_en),
      .i_tick     (tick),
      .o_is_one   (w_cnt_is_one)
   );

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_pulse_inc  = 1'b0;
      w_load       = 1'b0;
      w_load_val   = r_high;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (burst_len != '0) begin
                  w_state_next = HIGH;
                  w_load       = 1'b1;
                  w_load_val   = high_ticks;
               end else begin
                  w_state_next = DONE;
               end
            end
         end
         HIGH: begin
            if (abort) begin
               w_state_next = DONE;
            end else if (tick && w_cnt_is_one) begin
               w_pulse_inc = 1'b1;
               if (w_last) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = LOW;
                  w_load       = 1'b1;
                  w_load_val   = r_low;
               end
            end
         end
         LOW: begin
            if (abort) begin
               w_state_next = DONE;
            end else if (tick && w_cnt_is_one) begin
               w_state_next = HIGH;
               w_load       = 1'b1;
               w_load_val   = r_high;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_high      <= '0;
         r_low       <= '0;
         r_pulse_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_len       <= burst_len;
            r_high      <= high_ticks;
            r_low       <= low_ticks;
            r_pulse_cnt <= '0;
         end else if (w_pulse_inc) begin
            r_pulse_cnt <= w_cnt_plus1[CNT_W-1:0];
         end
      end
   end

   assign pulse_out = (r_state == HIGH);
   assign done      = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Directed bench for tick_burst_gen: hand-computed per-cycle expectations
// for nominal, zero-length, sparse-tick, abort, reset, ignored-input and full-length bursts.
module tb_tick_burst_gen;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       start;
   logic       abort;
   logic [7:0] burst_len;
   logic [7:0] high_ticks;
   logic [7:0] low_ticks;
   logic       pulse_out;
   logic       busy;
   logic       done;
   logic [7:0] pulse_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Nominal burst len=3 high=2 low=1, cycles 1..10
   int e1_p [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
   int e1_b [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   int e1_d [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   int e1_c [10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

   // len=2 with zero widths, cycles 1..5
   int e6_p [5] = '{1, 0, 1, 0, 0};
   int e6_b [5] = '{1, 1, 1, 1, 0};
   int e6_d [5] = '{0, 0, 0, 1, 0};
   int e6_c [5] = '{0, 1, 1, 2, 2};

   tick_burst_gen dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .start      (start),
      .abort      (abort),
      .burst_len  (burst_len),
      .high_ticks (high_ticks),
      .low_ticks  (low_ticks),
      .pulse_out  (pulse_out),
      .busy       (busy),
      .done       (done),
      .pulse_cnt  (pulse_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int p, input int b, input int d, input int c);
      logic [10:0] obs;
      logic [10:0] exp_v;
      obs   = {pulse_out, busy, done, pulse_cnt};
      exp_v = {p[0], b[0], d[0], c[7:0]};
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed pulse/busy/done/cnt=%b/%b/%b/%0d expected %0d/%0d/%0d/%0d",
                tag, obs[10], obs[9], obs[8], obs[7:0], p, b, d, c);
      end
      $display("check %s: pulse=%b busy=%b done=%b cnt=%0d", tag, pulse_out, busy, done, pulse_cnt);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; abort = 1'b0;
      burst_len = 8'd0; high_ticks = 8'd0; low_ticks = 8'd0;
      step();
      step();
      expect_out("reset", 0, 0, 0, 0);
      reset = 1'b0;
      step();
      expect_out("idle", 0, 0, 0, 0);

      // Nominal burst, tick every cycle
      burst_len = 8'd3; high_ticks = 8'd2; low_ticks = 8'd1; tick = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         expect_out($sformatf("nominal c%0d", c), e1_p[c-1], e1_b[c-1], e1_d[c-1], e1_c[c-1]);
         step();
      end

      // Zero-length burst goes straight to DONE and clears pulse_cnt
      burst_len = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      expect_out("zero_len c1", 0, 1, 1, 0);
      step();
      expect_out("zero_len c2", 0, 0, 0, 0);

      // Sparse ticks (every 3rd cycle), len=1 high=2: high cycles 1..6, done at 7
      burst_len = 8'd1; high_ticks = 8'd2; low_ticks = 8'd1; tick = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         expect_out($sformatf("sparse c%0d", c), (c <= 6) ? 1 : 0, (c <= 7) ? 1 : 0,
                    (c == 7) ? 1 : 0, (c >= 7) ? 1 : 0);
         tick = ((c % 3) == 0);
         step();
      end

      // Abort during second HIGH of len=4 (high=2, low=2): abort in cycle 5
      burst_len = 8'd4; high_ticks = 8'd2; low_ticks = 8'd2; tick = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) step();
      expect_out("abort c5", 1, 1, 0, 1);
      abort = 1'b1;
      step();
      expect_out("abort c6", 0, 1, 1, 1);
      step();
      abort = 1'b0;
      expect_out("abort c7", 0, 0, 0, 1);

      // Reset mid-LOW (len=3 high=1 low=3): reset with start asserted in cycle 3
      burst_len = 8'd3; high_ticks = 8'd1; low_ticks = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      expect_out("rst_burst c1", 1, 1, 0, 0);
      step();
      expect_out("rst_burst c2", 0, 1, 0, 1);
      step();
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      expect_out("rst_burst c4", 0, 0, 0, 0);
      step();
      expect_out("rst_burst c5", 0, 0, 0, 0);

      // Zero widths act as 1; start and width changes mid-burst are ignored
      burst_len = 8'd2; high_ticks = 8'd0; low_ticks = 8'd0; start = 1'b1;
      step();
      for (int c = 1; c <= 5; c++) begin
         expect_out($sformatf("ignored c%0d", c), e6_p[c-1], e6_b[c-1], e6_d[c-1], e6_c[c-1]);
         start      = (c <= 3);
         burst_len  = 8'd9;
         high_ticks = 8'd5;
         low_ticks  = 8'd7;
         step();
      end
      start = 1'b0;

      // Full-length burst of 255 pulses, high=1 low=1: last HIGH at 509, DONE at 510
      burst_len = 8'd255; high_ticks = 8'd1; low_ticks = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 509; c++) step();
      expect_out("maxlen c509", 1, 1, 0, 254);
      step();
      expect_out("maxlen c510", 0, 1, 1, 255);
      step();
      expect_out("maxlen c511", 0, 0, 0, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
